// File: rtl/IO_UnitTypes.sv
// Shared types for the IO unit serial transmit path.
// SERIAL_TX_PARITY_EN adds the PARITY state to the transmit FSM encoding.
package IO_UnitTypes;

  typedef logic [7:0] SerialDataPath;

  localparam int SERIAL_TX_DEFAULT_CLKS_PER_BIT = 868;

`ifdef SERIAL_TX_PARITY_EN
  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } SerialTxState;
`else
  typedef enum logic [1:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP
  } SerialTxState;
`endif

endpackage

// File: rtl/serial_tx_fifo.sv
// Circular byte FIFO with head/tail pointers and a separate occupancy count.
// A push while full is accepted only if a pop frees a slot in the same cycle.
module serial_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             drop,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && !push_ok;
  assign rdata   = mem_q[head_q];
  assign count   = count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop_ok)  head_d = head_q + AW'(1);
    if (push_ok) tail_d = tail_q + AW'(1);
    if (push_ok && !pop_ok)      count_d = count_q + (AW+1)'(1);
    else if (pop_ok && !push_ok) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; at full, the slot being written is the one read out this cycle.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem_q[tail_q] <= wdata;
  end

endmodule

// File: rtl/io_serial_tx_controller.sv
// Buffers IO-unit serial byte writes and sends them as UART frames on txOut.
// SERIAL_TX_PARITY_EN: append an even-parity bit (8E1) instead of plain 8N1.
module io_serial_tx_controller
  import IO_UnitTypes::*;
#(
  parameter int FIFO_DEPTH   = 16,
  parameter int CLKS_PER_BIT = SERIAL_TX_DEFAULT_CLKS_PER_BIT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        serialWE,
  input  logic [7:0]                  serialWriteDataIn,
  output logic                        txOut,
  output logic                        busyOut,
  output logic [$clog2(FIFO_DEPTH):0] fifoCountOut,
  output logic                        overflowOut
);

  localparam int TW = $clog2(CLKS_PER_BIT);

  SerialTxState  state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  SerialDataPath shift_q, shift_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic          tx_q, tx_d;
  logic          overflow_q, overflow_d;
`ifdef SERIAL_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  logic          fifo_pop, fifo_full, fifo_empty, fifo_drop;
  SerialDataPath fifo_rdata;
  logic          bit_done;

  serial_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (serialWE),
    .wdata (serialWriteDataIn),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .drop  (fifo_drop),
    .count (fifoCountOut)
  );

  assign bit_done = (timer_q == TW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q + TW'(1);
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    tx_d       = 1'b1;
    fifo_pop   = 1'b0;
    overflow_d = overflow_q | fifo_drop;
`ifdef SERIAL_TX_PARITY_EN
    par_d      = par_q;
`endif
    case (state_q)
      TX_IDLE: begin
        timer_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
`ifdef SERIAL_TX_PARITY_EN
          par_d    = ^fifo_rdata;
`endif
          state_d  = TX_START;
        end
      end
      TX_START: begin
        tx_d = 1'b0;
        if (bit_done) begin
          timer_d   = '0;
          bit_idx_d = '0;
          state_d   = TX_DATA;
        end
      end
      TX_DATA: begin
        tx_d = shift_q[0];
        if (bit_done) begin
          timer_d   = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
`ifdef SERIAL_TX_PARITY_EN
          if (bit_idx_q == 3'd7) state_d = TX_PARITY;
`else
          if (bit_idx_q == 3'd7) state_d = TX_STOP;
`endif
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      TX_PARITY: begin
        tx_d = par_q;
        if (bit_done) begin
          timer_d = '0;
          state_d = TX_STOP;
        end
      end
`endif
      TX_STOP: begin
        if (bit_done) begin
          timer_d = '0;
          state_d = TX_IDLE;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // txOut is registered from the current state, so the line lags the FSM by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= TX_IDLE;
      timer_q    <= '0;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_d;
`ifdef SERIAL_TX_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  assign txOut       = tx_q;
  assign overflowOut = overflow_q;
  assign busyOut     = (state_q != TX_IDLE) || (fifoCountOut != '0);

endmodule
